// File: rtl/led_pattern_arbiter.sv
// led_pattern_arbiter
//   Round-robin owner of a 5-bit LED bank shared by two pattern sequences.
//   req[0] requests the rotate sequence, req[1] the blink sequence. A granted
//   sequence runs for 6 steps of STEP_DIV enabled cycles each, then pulses
//   done for its requester and returns to idle for at least one cycle.
//
// Parameters
//   STEP_DIV  - enabled clock cycles per pattern step (2 .. 2^24-1)
//   DIV_WIDTH - step divider width in bits
//
// Ports
//   clk    in   single clock, posedge
//   reset  in   synchronous active-high reset
//   enable in   step timebase gate; low pauses the running sequence
//   req    in   [1:0] level requests (0 = rotate, 1 = blink)
//   abort  in   (only with LED_ARB_ABORT_EN) drop the running sequence
//   grant  out  [1:0] one-hot owner, 0 when idle
//   busy   out  a sequence is running
//   done   out  [1:0] one-cycle completion pulse per requester
//   leds   out  [4:0] registered LED drive
//
// Build option
//   LED_ARB_ABORT_EN - adds the abort input. Without it every granted
//                      sequence runs to completion or reset.

module led_pattern_arbiter #(
    parameter int unsigned STEP_DIV  = 1200000,
    parameter int unsigned DIV_WIDTH = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
`ifdef LED_ARB_ABORT_EN
    input  logic       abort,
`endif
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       busy,
    output logic [1:0] done,
    output logic [4:0] leds
);

    localparam logic [DIV_WIDTH-1:0] DivLast = DIV_WIDTH'(STEP_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] DivOne  = DIV_WIDTH'(1);
    localparam logic [2:0]           StepLast = 3'd5;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [2:0]           step_q;
    // Requester served most recently; 1 after reset so req[0] wins the first tie.
    logic                 last_q;
    logic [1:0]           pick;

    function automatic logic [4:0] pattern(input logic blink, input logic [2:0] idx);
        logic [4:0] p;
        p = 5'h00;
        if (blink) begin
            p = idx[0] ? 5'h00 : 5'h1F;
        end else begin
            case (idx)
                3'd0:    p = 5'h01;
                3'd1:    p = 5'h03;
                3'd2:    p = 5'h06;
                3'd3:    p = 5'h0C;
                3'd4:    p = 5'h08;
                default: p = 5'h00;
            endcase
        end
        return p;
    endfunction

    // Single requester wins outright; on a tie the one not served last wins.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant   <= 2'b00;
            busy    <= 1'b0;
            done    <= 2'b00;
            leds    <= 5'h00;
            div_q   <= '0;
            step_q  <= 3'd0;
            last_q  <= 1'b1;
        end else begin
            done <= 2'b00;
            case (state_q)
                StIdle: begin
                    if (req != 2'b00) begin
                        state_q <= StRun;
                        grant   <= pick;
                        busy    <= 1'b1;
                        div_q   <= '0;
                        step_q  <= 3'd0;
                        leds    <= pattern(pick[1], 3'd0);
                    end
                end
                StRun: begin
`ifdef LED_ARB_ABORT_EN
                    if (abort) begin
                        state_q <= StIdle;
                        grant   <= 2'b00;
                        busy    <= 1'b0;
                        leds    <= 5'h00;
                        div_q   <= '0;
                        step_q  <= 3'd0;
                        last_q  <= grant[1];
                    end else
`endif
                    if (!enable) begin
                        // Pause: a resumed step gets a full period again.
                        div_q <= '0;
                    end else if (div_q != DivLast) begin
                        div_q <= div_q + DivOne;
                    end else begin
                        div_q <= '0;
                        if (step_q == StepLast) begin
                            state_q <= StIdle;
                            done    <= grant;
                            grant   <= 2'b00;
                            busy    <= 1'b0;
                            leds    <= 5'h00;
                            step_q  <= 3'd0;
                            last_q  <= grant[1];
                        end else begin
                            step_q <= step_q + 3'd1;
                            leds   <= pattern(grant[1], step_q + 3'd1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Bench for led_pattern_arbiter with STEP_DIV=4. A cycle-level model built
// from the sequence tables and step timing is compared to every output on
// every falling edge; directed tests add hand-computed literal checks.
module tb_led_pattern_arbiter;

    localparam int unsigned StepDiv = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] grant;
    logic       busy;
    logic [1:0] done;
    logic [4:0] leds;
`ifdef LED_ARB_ABORT_EN
    logic       abort = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    led_pattern_arbiter #(
        .STEP_DIV (StepDiv),
        .DIV_WIDTH(24)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
`ifdef LED_ARB_ABORT_EN
        .abort (abort),
`endif
        .req   (req),
        .grant (grant),
        .busy  (busy),
        .done  (done),
        .leds  (leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int rot_tab[6]   = '{'h01, 'h03, 'h06, 'h0C, 'h08, 'h00};
    int blink_tab[6] = '{'h1F, 'h00, 'h1F, 'h00, 'h1F, 'h00};

    bit m_run;
    int m_owner;
    int m_step;
    int m_cnt;       // enabled cycles spent in the current step
    int m_last = 1;  // requester served last
    logic [1:0] e_grant, e_done;
    logic       e_busy;
    logic [4:0] e_leds;

    always @(posedge clk) begin
        e_done = 2'b00;
        if (reset) begin
            m_run = 0; m_step = 0; m_cnt = 0; m_last = 1;
        end else if (!m_run) begin
            if (req != 2'b00) begin
                if (req == 2'b11) m_owner = (m_last == 0) ? 1 : 0;
                else              m_owner = req[1] ? 1 : 0;
                m_run = 1; m_step = 0; m_cnt = 0;
            end
        end
`ifdef LED_ARB_ABORT_EN
        else if (abort) begin
            m_run = 0; m_last = m_owner;
        end
`endif
        else if (!enable) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt == StepDiv) begin
                m_cnt = 0;
                m_step++;
                if (m_step == 6) begin
                    m_run = 0;
                    e_done = (m_owner == 1) ? 2'b10 : 2'b01;
                    m_last = m_owner;
                end
            end
        end
        e_busy  = m_run;
        e_grant = !m_run ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01);
        e_leds  = !m_run ? 5'h00 : 5'((m_owner == 1) ? blink_tab[m_step] : rot_tab[m_step]);
    end

    always @(negedge clk) begin
        if (checking) begin
            check("model_grant", {6'b0, grant}, {6'b0, e_grant});
            check("model_busy", {7'b0, busy}, {7'b0, e_busy});
            check("model_done", {6'b0, done}, {6'b0, e_done});
            check("model_leds", {3'b0, leds}, {3'b0, e_leds});
            check("grant_onehot", 8'($countones(grant) <= 1), 8'd1);
        end
    end

    // ---------------- directed stimulus ----------------
    // Hold reset two edges, check reset outputs, release with request r.
    task automatic do_reset(input logic [1:0] r);
        reset = 1'b1; req = 2'b00; enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checking = 1'b1;
        check("rst_grant", {6'b0, grant}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_leds", {3'b0, leds}, 8'h00);
        reset = 1'b0; req = r;
    endtask

    int busy_cnt;
    int k;
    bit seen_done;

    initial begin
        // Rotate alone: literal timeline.
        do_reset(2'b01);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) check("t1_grant", {6'b0, grant}, 8'h01);
            if (c <= 24) check("t1_leds", {3'b0, leds}, 8'(rot_tab[(c - 1) / 4]));
            if (c == 5) check("t1_leds_c5", {3'b0, leds}, 8'h03);
            if (c == 24) check("t1_done_c24", {6'b0, done}, 8'h00);
            if (c == 25) begin
                check("t1_done", {6'b0, done}, 8'h01);
                check("t1_idle_leds", {3'b0, leds}, 8'h00);
                check("t1_idle_busy", {7'b0, busy}, 8'h00);
            end
            if (c == 26) check("t1_regrant", {6'b0, grant}, 8'h01);
        end

        // Both requesting: alternating grants.
        do_reset(2'b11);
        for (int c = 1; c <= 51; c++) begin
            @(negedge clk);
            if (c == 1)  check("t2_grant0", {6'b0, grant}, 8'h01);
            if (c == 25) check("t2_done0", {6'b0, done}, 8'h01);
            if (c == 26) check("t2_grant1", {6'b0, grant}, 8'h10 >> 3);
            if (c == 26) check("t2_blink_on", {3'b0, leds}, 8'h1F);
            if (c == 30) check("t2_blink_off", {3'b0, leds}, 8'h00);
            if (c == 34) check("t2_blink_on2", {3'b0, leds}, 8'h1F);
            if (c == 50) check("t2_done1", {6'b0, done}, 8'h02);
            if (c == 51) check("t2_grant2", {6'b0, grant}, 8'h01);
        end

        // Pause for 10 cycles at the start of step 2.
        do_reset(2'b01);
        busy_cnt = 0; seen_done = 0; k = 0;
        while (!seen_done && k < 100) begin
            @(negedge clk);
            k++;
            if (busy) busy_cnt++;
            if (done != 2'b00) seen_done = 1;
            if (k == 9) enable = 1'b0;
            if (k == 19) enable = 1'b1;
            if (k == 15) check("t3_pause_leds", {3'b0, leds}, 8'h06);
            if (k == 22) check("t3_resume_leds", {3'b0, leds}, 8'h06);
            if (k == 23) check("t3_step3_leds", {3'b0, leds}, 8'h0C);
        end
        check("t3_done_seen", {7'b0, seen_done}, 8'h01);
        check("t3_busy_cycles", 8'(busy_cnt), 8'd34);
        req = 2'b00;

        // Reset in step 3 of blink aborts, pointer back to req[0].
        do_reset(2'b11);
        for (int c = 1; c <= 39; c++) @(negedge clk);
        check("t4_pre_grant", {6'b0, grant}, 8'h02);
        check("t4_pre_leds", {3'b0, leds}, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        check("t4_rst_grant", {6'b0, grant}, 8'h00);
        check("t4_rst_busy", {7'b0, busy}, 8'h00);
        check("t4_rst_done", {6'b0, done}, 8'h00);
        check("t4_rst_leds", {3'b0, leds}, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        check("t4_regrant", {6'b0, grant}, 8'h01);
        for (int c = 0; c < 30; c++) @(negedge clk);

`ifdef LED_ARB_ABORT_EN
        // Abort during step 1 of rotate.
        do_reset(2'b11);
        for (int c = 1; c <= 5; c++) @(negedge clk);
        check("t5_step1_leds", {3'b0, leds}, 8'h03);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_busy", {7'b0, busy}, 8'h00);
        check("t5_abort_leds", {3'b0, leds}, 8'h00);
        check("t5_abort_done", {6'b0, done}, 8'h00);
        @(negedge clk);
        check("t5_next_grant", {6'b0, grant}, 8'h02);
        for (int c = 0; c < 30; c++) @(negedge clk);
`endif

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
